// File: rtl/instruction_encoder.sv
// instruction_encoder: packs per-field instruction requests into 32-bit words,
// validates them, tags each legal word with its program address and queues it
// in a show-ahead FIFO that drains over a valid/ready stream.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. Valid is never withdrawn by this block once raised, and payload holds
// steady while valid && !ready. in_ready also drops during a restart request,
// so a request presented together with restart is never taken.
module instruction_encoder #(
  parameter int                DEPTH       = 4,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter bit                STOP_ON_ERR = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_type,
  input  logic [5:0]                   in_rd,
  input  logic [5:0]                   in_rs1,
  input  logic [5:0]                   in_rs2,
  input  logic                         in_use_imm,
  input  logic [15:0]                  in_imm,
  input  logic [3:0]                   in_op,
  input  logic [3:0]                   in_pred_reg,
  input  logic                         in_pred_comp,
  input  logic                         restart,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_word,
  output logic [ADDR_W-1:0]            out_addr,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         err_pulse,
  output logic [2:0]                   err_code,
  output logic [15:0]                  err_count,
  output logic                         warn_imm9,
  output logic [1:0]                   fsm_state
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_ERROR = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] next_addr;
  logic [31:0]       word_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [LW-1:0]     count;
  logic [31:0]       enc_word;
  logic [3:0]        eff_op;
  logic [2:0]        chk_code;
  logic              accept;
  logic              push;
  logic              pop;
  logic              illegal;
  logic              drain_done;

  // Pack the request fields and classify legality; the immediate form forces bit 9.
  always_comb begin
    enc_word = in_use_imm ? {in_type, in_rd, in_rs1, in_imm[15:10], 1'b1, in_imm[8:0]}
                          : {in_type, in_rd, in_rs1, in_rs2, 1'b0, in_op, in_pred_reg, in_pred_comp};
    eff_op   = in_use_imm ? in_imm[8:5] : in_op;
    chk_code = 3'd0;
    if (in_type > 4'd7)
      chk_code = 3'd1;
    else if (in_type == 4'd0 && eff_op > 4'd13)
      chk_code = 3'd2;
    else if (in_type == 4'd1 && eff_op[3])
      chk_code = 3'd3;
    else if ((in_type == 4'd2 || in_type == 4'd3 || in_type == 4'd5) && eff_op[3:2] != 2'b00)
      chk_code = 3'd4;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= state_nx;
  end

  // FSM next-state: restart always goes through DRAIN, which exits once empty.
  always_comb begin
    state_nx = state;
    case (state)
      S_RUN: begin
        if (restart)                   state_nx = S_DRAIN;
        else if (illegal && STOP_ON_ERR) state_nx = S_ERROR;
      end
      S_ERROR: if (restart)            state_nx = S_DRAIN;
      S_DRAIN: if (count == '0)        state_nx = S_RUN;
      default:                         state_nx = S_RUN;
    endcase
  end

  // FSM outputs and the handshake qualifiers derived from them.
  always_comb begin
    in_ready   = (state == S_RUN) && (count != FULL) && !restart;
    drain_done = (state == S_DRAIN) && (count == '0);
    accept     = in_valid && in_ready;
    push       = accept && (chk_code == 3'd0);
    illegal    = accept && (chk_code != 3'd0);
    pop        = out_ready && (count != '0);
  end

  // FIFO pointers and occupancy; a reset throws away every queued entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // FIFO storage; contents are only visible through the gated head below.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr] <= enc_word;
      addr_mem[wr_ptr] <= next_addr;
    end
  end

  // Program address: advances per legal word, reloads when a drain completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             next_addr <= BASE_ADDR;
    else if (push)       next_addr <= next_addr + ADDR_W'(4);
    else if (drain_done) next_addr <= BASE_ADDR;
  end

  // Error and warning reporting; err_code/err_count survive restart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_code  <= 3'd0;
      err_count <= 16'd0;
      warn_imm9 <= 1'b0;
    end else begin
      err_pulse <= illegal;
      warn_imm9 <= accept && in_use_imm && !in_imm[9];
      if (illegal) begin
        err_code <= chk_code;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

  // Show-ahead head of the FIFO, forced to zero while empty.
  always_comb begin
    out_valid  = (count != '0);
    out_word   = out_valid ? word_mem[rd_ptr] : 32'd0;
    out_addr   = out_valid ? addr_mem[rd_ptr] : '0;
    fifo_level = count;
    fsm_state  = state;
  end

endmodule
